input_window_fetcher: RTL and testbench

//  Read-side front end of the convolution datapath: reads the packed 3x3 kernel from weights SRAM and

---
 rtl/conv_pkg.sv | 23 ++
 rtl/input_window_fetcher_word_unpacker.sv | 19 +
 rtl/input_window_fetcher.sv | 228 ++++++++++++++++++++++
 tb/tb_input_window_fetcher.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the convolution datapath read side: byte/word
// geometry, kernel and window sizes, the dimension word that terminates
// the record stream, and the fetcher state encoding.
package conv_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 16;
    localparam int KERN_BYTES = 9;
    localparam int WIN_BYTES  = 16;

    localparam logic [WORD_W-1:0] TERM_DIM = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KERN,
        ST_DIM,
        ST_FETCH,
        ST_PRESENT,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/input_window_fetcher_word_unpacker.sv
// word_unpacker
// Splits one 16-bit SRAM word into its two signed pixel/weight bytes.
// The upper byte of the word holds the lower column index.
// Ports:
//   word         in   16  packed SRAM word
//   lo_col_byte  out  8   byte of the lower column (word bits [15:8])
//   hi_col_byte  out  8   byte of the higher column (word bits [7:0])
module word_unpacker
    import conv_pkg::*;
(
    input  logic        [WORD_W-1:0] word,
    output logic signed [BYTE_W-1:0] lo_col_byte,
    output logic signed [BYTE_W-1:0] hi_col_byte
);

    assign lo_col_byte = word[WORD_W-1 -: BYTE_W];
    assign hi_col_byte = word[BYTE_W-1:0];

endmodule

// File: rtl/input_window_fetcher.sv
// input_window_fetcher
// Read-side front end of the convolution datapath. Loads the 3x3 kernel
// once per run from weights SRAM, then walks the record stream in input
// SRAM ([dim word N][N*N/2 pixel words]) and hands one 4x4 pixel window per
// 2x2-pooled output to the MAC engine over a valid/ready handshake.
// Ports:
//   clk, reset_b                clock, synchronous active-low reset
//   dut_run                     start request, honoured in IDLE only
//   fetch_busy                  high from run acceptance until the terminator is handled
//   input_sram_read_address     registered input SRAM address
//   input_sram_read_data        data for the address presented the previous cycle
//   weights_sram_read_address   registered weights SRAM address
//   weights_sram_read_data      data for the address presented the previous cycle
//   kern_data                   kernel byte k=row*3+col at [8k+7:8k]
//   win_valid/win_ready         window handshake
//   win_data                    window byte i=row*4+col at [8i+7:8i]
//   win_last                    last window of the current matrix
module input_window_fetcher
    import conv_pkg::*;
#(
    parameter int MAX_DIM = 64,
    parameter int ADDR_W  = 12
) (
    input  logic                             clk,
    input  logic                             reset_b,
    input  logic                             dut_run,
    output logic                             fetch_busy,
    output logic [ADDR_W-1:0]                input_sram_read_address,
    input  logic [WORD_W-1:0]                input_sram_read_data,
    output logic [ADDR_W-1:0]                weights_sram_read_address,
    input  logic [WORD_W-1:0]                weights_sram_read_data,
    output logic [KERN_BYTES*BYTE_W-1:0]     kern_data,
    output logic                             win_valid,
    input  logic                             win_ready,
    output logic [WIN_BYTES*BYTE_W-1:0]      win_data,
    output logic                             win_last
);

    localparam int DIM_W = $clog2(MAX_DIM + 1);
    localparam int IDX_W = DIM_W - 1;

    fetch_state_t state;
    fetch_state_t state_next;

    logic [3:0]        step;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [IDX_W-1:0]  half_n;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  row_idx;
    logic [IDX_W-1:0]  col_idx;
    logic [IDX_W-1:0]  row_next;
    logic [IDX_W-1:0]  col_next;
    logic              col_wrap;
    logic              matrix_end;
    logic              is_term;

    logic signed [BYTE_W-1:0] in_lo_col;
    logic signed [BYTE_W-1:0] in_hi_col;
    logic signed [BYTE_W-1:0] wt_lo_col;
    logic signed [BYTE_W-1:0] wt_hi_col;

    word_unpacker u_input_unpacker (
        .word        (input_sram_read_data),
        .lo_col_byte (in_lo_col),
        .hi_col_byte (in_hi_col)
    );

    word_unpacker u_weights_unpacker (
        .word        (weights_sram_read_data),
        .lo_col_byte (wt_lo_col),
        .hi_col_byte (wt_hi_col)
    );

    // Address of word w (0..7) of window (r,c): row 2r+w[2:1], word column c+w[0].
    // Wraps modulo 2^ADDR_W on purpose.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [IDX_W-1:0]  half,
        input logic [IDX_W-1:0]  r,
        input logic [IDX_W-1:0]  c,
        input logic [2:0]        w
    );
        logic [ADDR_W-1:0] pix_row;
        pix_row = ADDR_W'({r, 1'b0}) + ADDR_W'(w[2:1]);
        return base + ADDR_W'(1) + pix_row * ADDR_W'(half) + ADDR_W'(c) + ADDR_W'(w[0]);
    endfunction

    // Any dimension that cannot produce a whole number of pooled windows ends the stream.
    assign is_term = (input_sram_read_data == TERM_DIM) || input_sram_read_data[0] ||
                     (input_sram_read_data < 16'd4) ||
                     (input_sram_read_data > 16'(MAX_DIM));

    // Window index of the last row/column of windows is (N-2)/2 - 1 = N/2 - 2.
    assign last_idx   = half_n - IDX_W'(2);
    assign col_wrap   = (col_idx == last_idx);
    assign matrix_end = col_wrap && (row_idx == last_idx);
    assign col_next   = col_wrap ? '0 : col_idx + IDX_W'(1);
    assign row_next   = col_wrap ? row_idx + IDX_W'(1) : row_idx;
    // Next record starts after the dim word and N*N/2 = 2*(N/2)^2 pixel words.
    assign ptr_next   = ptr + ADDR_W'(1) + ((ADDR_W'(half_n) * ADDR_W'(half_n)) << 1);

    assign win_valid = (state == ST_PRESENT);
    assign win_last  = win_valid && (row_idx == last_idx) && (col_idx == last_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DIM takes two cycles: the address goes out on entry,
    // the dimension word is judged on the second cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (dut_run) state_next = ST_KERN;
            ST_KERN:    if (step == 4'd5) state_next = ST_DIM;
            ST_DIM:     if (step == 4'd1) state_next = is_term ? ST_DONE : ST_FETCH;
            ST_FETCH:   if (step == 4'd8) state_next = ST_PRESENT;
            ST_PRESENT: if (win_ready) state_next = matrix_end ? ST_DIM : ST_FETCH;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Per-state cycle counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            step <= '0;
        end else if (state_next != state) begin
            step <= '0;
        end else if (state inside {ST_KERN, ST_DIM, ST_FETCH}) begin
            step <= step + 4'd1;
        end
    end

    // Kernel load: addresses 0..4 on steps 0..4, each word captured one step later.
    // The low byte of word 4 is padding and is dropped.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            weights_sram_read_address <= '0;
            kern_data                 <= '0;
        end else if (state == ST_IDLE && dut_run) begin
            weights_sram_read_address <= '0;
        end else if (state == ST_KERN) begin
            if (step < 4'd4) begin
                weights_sram_read_address <= ADDR_W'(step) + ADDR_W'(1);
            end
            case (step)
                4'd1: kern_data[15:0]  <= {wt_hi_col, wt_lo_col};
                4'd2: kern_data[31:16] <= {wt_hi_col, wt_lo_col};
                4'd3: kern_data[47:32] <= {wt_hi_col, wt_lo_col};
                4'd4: kern_data[63:48] <= {wt_hi_col, wt_lo_col};
                4'd5: kern_data[71:64] <= wt_lo_col;
                default: ;
            endcase
        end
    end

    // Record walk: dim read, window fetch (8 addresses, 8 captures, one step
    // apart) and the row/column/pointer advance on each accepted window.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            fetch_busy              <= 1'b0;
            ptr                     <= '0;
            half_n                  <= '0;
            row_idx                 <= '0;
            col_idx                 <= '0;
            input_sram_read_address <= '0;
            win_data                <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dut_run) begin
                        fetch_busy <= 1'b1;
                        ptr        <= '0;
                    end
                end
                ST_KERN: begin
                    if (step == 4'd5) begin
                        input_sram_read_address <= ptr;
                    end
                end
                ST_DIM: begin
                    if (step == 4'd1 && !is_term) begin
                        half_n                  <= input_sram_read_data[DIM_W-1:1];
                        row_idx                 <= '0;
                        col_idx                 <= '0;
                        input_sram_read_address <= ptr + ADDR_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (step < 4'd7) begin
                        input_sram_read_address <= word_addr(ptr, half_n, row_idx, col_idx,
                                                             3'(step + 4'd1));
                    end
                    for (int w = 0; w < 8; w++) begin
                        if (step == 4'(w + 1)) begin
                            win_data[16*w +: 16] <= {in_hi_col, in_lo_col};
                        end
                    end
                end
                ST_PRESENT: begin
                    if (win_ready) begin
                        row_idx <= row_next;
                        col_idx <= col_next;
                        if (matrix_end) begin
                            ptr                     <= ptr_next;
                            input_sram_read_address <= ptr_next;
                        end else begin
                            input_sram_read_address <= word_addr(ptr, half_n, row_next, col_next,
                                                                 3'd0);
                        end
                    end
                end
                ST_DONE: begin
                    fetch_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_input_window_fetcher.sv
// tb_input_window_fetcher
// Directed bench for input_window_fetcher: behavioural 1-cycle-latency SRAMs,
// records loaded by hand, windows and kernel compared against values
// computed from the pixel/kernel patterns written into memory.
module tb_input_window_fetcher;

    logic          clk;
    logic          reset_b;
    logic          dut_run;
    logic          fetch_busy;
    logic [11:0]   input_sram_read_address;
    logic [15:0]   input_sram_read_data;
    logic [11:0]   weights_sram_read_address;
    logic [15:0]   weights_sram_read_data;
    logic [71:0]   kern_data;
    logic          win_valid;
    logic          win_ready;
    logic [127:0]  win_data;
    logic          win_last;

    logic [15:0] input_mem   [0:4095];
    logic [15:0] weights_mem [0:4095];

    int tests_run    = 0;
    int tests_failed = 0;

    input_window_fetcher dut (
        .clk                       (clk),
        .reset_b                   (reset_b),
        .dut_run                   (dut_run),
        .fetch_busy                (fetch_busy),
        .input_sram_read_address   (input_sram_read_address),
        .input_sram_read_data      (input_sram_read_data),
        .weights_sram_read_address (weights_sram_read_address),
        .weights_sram_read_data    (weights_sram_read_data),
        .kern_data                 (kern_data),
        .win_valid                 (win_valid),
        .win_ready                 (win_ready),
        .win_data                  (win_data),
        .win_last                  (win_last)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM models: address sampled at the edge, data valid the next cycle.
    always @(posedge clk) begin
        input_sram_read_data   <= input_mem[input_sram_read_address];
        weights_sram_read_data <= weights_mem[weights_sram_read_address];
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse dut_run for one cycle; returns at the negedge after acceptance.
    task automatic applyStimulus();
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 4096; i++) begin
            input_mem[i]   = 16'hFFFF;
            weights_mem[i] = 16'h0000;
        end
    endtask

    // Kernel byte k = base + k; word m = {byte 2m, byte 2m+1}; word 4 low byte is filler.
    task automatic loadKernel(input int base);
        for (int m = 0; m < 4; m++) begin
            weights_mem[m] = {8'(base + 2*m), 8'(base + 2*m + 1)};
        end
        weights_mem[4] = {8'(base + 8), 8'h5A};
    endtask

    // Pixel (row,col) = base + row*n + col; lower column in the upper byte.
    task automatic loadRecord(input int addr, input int n, input int base);
        input_mem[12'(addr)] = 16'(n);
        for (int row = 0; row < n; row++) begin
            for (int wc = 0; wc < n/2; wc++) begin
                input_mem[12'(addr + 1 + row*(n/2) + wc)] =
                    {8'(base + row*n + 2*wc), 8'(base + row*n + 2*wc + 1)};
            end
        end
    endtask

    function automatic logic [127:0] expWin(input int n, input int r, input int c, input int base);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w[8*(i*4+j) +: 8] = 8'(base + (2*r + i)*n + 2*c + j);
            end
        end
        return w;
    endfunction

    // Wait (bounded) for the next window and check it at a negedge.
    task automatic waitWindow(input string tag, input logic [127:0] expData, input logic expLast);
        int cycles;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!win_valid && cycles < 200);
        checkOutput({tag, "_valid"}, 128'(win_valid), 128'd1);
        checkOutput({tag, "_data"}, win_data, expData);
        checkOutput({tag, "_last"}, 128'(win_last), 128'(expLast));
    endtask

    // Wait (bounded) for fetch_busy to drop, counting any windows seen meanwhile.
    task automatic waitIdle(input string tag);
        int cycles;
        int extra;
        cycles = 0;
        extra  = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (win_valid) extra++;
        end while (fetch_busy && cycles < 300);
        checkOutput({tag, "_busy_low"}, 128'(fetch_busy), 128'd0);
        checkOutput({tag, "_extra_windows"}, 128'(extra), 128'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 128'(fetch_busy), 128'd0);
        checkOutput({tag, "_valid"}, 128'(win_valid), 128'd0);
        checkOutput({tag, "_last"}, 128'(win_last), 128'd0);
        checkOutput({tag, "_iaddr"}, 128'(input_sram_read_address), 128'd0);
        checkOutput({tag, "_waddr"}, 128'(weights_sram_read_address), 128'd0);
        checkOutput({tag, "_kern"}, 128'(kern_data), 128'd0);
        checkOutput({tag, "_win"}, win_data, 128'd0);
    endtask

    // Directed sequence.
    initial begin
        logic [127:0] held;
        int           stable_err;

        reset_b   = 1'b0;
        dut_run   = 1'b0;
        win_ready = 1'b0;
        clearMem();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset_b = 1'b1;

        // Test 1: N=4, one window, kernel 1..9, terminator at 9.
        loadKernel(1);
        loadRecord(0, 4, 0);
        win_ready = 1'b1;
        applyStimulus();
        checkOutput("t1_busy_rise", 128'(fetch_busy), 128'd1);
        checkOutput("t1_waddr0", 128'(weights_sram_read_address), 128'd0);
        waitWindow("t1_w0", 128'h0f0e0d0c0b0a09080706050403020100, 1'b1);
        checkOutput("t1_kern", 128'(kern_data), 128'(72'h090807060504030201));
        @(negedge clk);
        checkOutput("t1_next_dim_addr", 128'(input_sram_read_address), 128'd9);
        waitIdle("t1");

        // Test 2: N=6, four windows, next dim at 19.
        clearMem();
        loadKernel(1);
        loadRecord(0, 6, 0);
        applyStimulus();
        waitWindow("t2_w0", expWin(6, 0, 0, 0), 1'b0);
        waitWindow("t2_w1", expWin(6, 0, 1, 0), 1'b0);
        waitWindow("t2_w2", expWin(6, 1, 0, 0), 1'b0);
        waitWindow("t2_w3", expWin(6, 1, 1, 0), 1'b1);
        @(negedge clk);
        checkOutput("t2_next_dim_addr", 128'(input_sram_read_address), 128'd19);
        waitIdle("t2");

        // Test 3: backpressure, 10 cycles of win_ready low while presenting.
        clearMem();
        loadKernel(1);
        loadRecord(0, 4, 40);
        win_ready = 1'b0;
        applyStimulus();
        waitWindow("t3_w0", expWin(4, 0, 0, 40), 1'b1);
        held       = win_data;
        stable_err = 0;
        repeat (10) begin
            @(negedge clk);
            if (!win_valid || win_data !== held) stable_err++;
        end
        checkOutput("t3_stable", 128'(stable_err), 128'd0);
        win_ready = 1'b1;
        @(negedge clk);
        checkOutput("t3_valid_after_xfer", 128'(win_valid), 128'd0);
        waitIdle("t3");

        // Test 4: N=4 then N=8 then terminator; kernel read once.
        clearMem();
        loadKernel(8'hF0);
        loadRecord(0, 4, 200);
        loadRecord(9, 8, 100);
        applyStimulus();
        waitWindow("t4_a0", expWin(4, 0, 0, 200), 1'b1);
        checkOutput("t4_kern", 128'(kern_data), 128'(72'hF8F7F6F5F4F3F2F1F0));
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                waitWindow($sformatf("t4_b%0d%0d", r, c), expWin(8, r, c, 100),
                           (r == 2 && c == 2));
                checkOutput($sformatf("t4_b%0d%0d_waddr", r, c),
                            128'(weights_sram_read_address), 128'd4);
            end
        end
        @(negedge clk);
        checkOutput("t4_next_dim_addr", 128'(input_sram_read_address), 128'd42);
        waitIdle("t4");

        // Test 5: odd dimension at address 0, nothing presented.
        clearMem();
        loadKernel(1);
        input_mem[0] = 16'd5;
        applyStimulus();
        checkOutput("t5_busy_rise", 128'(fetch_busy), 128'd1);
        waitIdle("t5");
        checkOutput("t5_iaddr", 128'(input_sram_read_address), 128'd0);

        // Test 6: reset during the second window fetch, then restart from 0.
        clearMem();
        loadKernel(1);
        loadRecord(0, 6, 0);
        applyStimulus();
        waitWindow("t6_w0", expWin(6, 0, 0, 0), 1'b0);
        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        checkAllZero("t6_reset");
        reset_b = 1'b1;
        applyStimulus();
        waitWindow("t6_r0", expWin(6, 0, 0, 0), 1'b0);
        waitWindow("t6_r1", expWin(6, 0, 1, 0), 1'b0);
        waitWindow("t6_r2", expWin(6, 1, 0, 0), 1'b0);
        waitWindow("t6_r3", expWin(6, 1, 1, 0), 1'b1);
        waitIdle("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
